// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus transaction sequencer: default widths,
// FSM state encoding and the bus address composition helper.
package bus_seq_pkg;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_SLV_AW         = 12;
  localparam int DEF_DEV_W          = 2;
  localparam int DEF_MEM_SW_W       = 6;
  localparam int DEF_BURST_W        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ISSUE       = 3'd1,
    S_WAIT_ACCEPT = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_READBACK    = 3'd4
  } seq_state_e;

  // Device select sits directly above the slave memory field; callers truncate.
  function automatic logic [63:0] compose_maddr(input logic [31:0] dev,
                                                input logic [31:0] off,
                                                input int          slv_aw);
    return (64'(dev) << slv_aw) | 64'(off);
  endfunction

endpackage

// File: rtl/start_edge_sync.sv
// Two-flop synchroniser for an asynchronous button followed by a
// rising-edge detector producing a single-cycle pulse.
module start_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/bus_txn_sequencer.sv
// Switch-driven burst generator for one master_interface user port.
// Optional write-then-readback verification is enabled by SEQ_READBACK_EN.
module bus_txn_sequencer
  import bus_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SLV_AW         = DEF_SLV_AW,
  parameter int DEV_W          = DEF_DEV_W,
  parameter int MEM_SW_W       = DEF_MEM_SW_W,
  parameter int BURST_W        = DEF_BURST_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode_sw,
  input  logic                  incr_sw,
  input  logic [DEV_W-1:0]      device_addr_sw,
  input  logic [MEM_SW_W-1:0]   slave_mem_addr_sw,
  input  logic [DATA_WIDTH-1:0] m_write_data_sw,
  input  logic [BURST_W-1:0]    burst_len_sw,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [DATA_WIDTH-1:0] mwdata,
  output logic                  mwvalid,
  output logic                  wen,
  input  logic [DATA_WIDTH-1:0] mrdata,
  input  logic                  mrvalid,
  input  logic                  mready,
  output logic [DATA_WIDTH-1:0] m_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
`ifdef SEQ_READBACK_EN
  output logic                  verify_err,
`endif
  output logic [BURST_W:0]      beat_count
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic                  mode_q, mode_d, incr_q, incr_d;
  logic [DEV_W-1:0]      dev_q, dev_d;
  logic [MEM_SW_W-1:0]   off_q, off_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BURST_W-1:0]    len_q, len_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d, rdata_q, rdata_d;
  logic                  mwvalid_q, mwvalid_d, wen_q, wen_d;
  logic                  busy_q, busy_d, done_q, done_d, terr_q, terr_d;
  logic [BURST_W:0]      beat_q, beat_d;
`ifdef SEQ_READBACK_EN
  logic                  rb_q, rb_d, verr_q, verr_d;
`endif

  logic                  start_pulse;
  logic                  complete;
  logic [BURST_W:0]      beat_inc, len_p1;
  logic [MEM_SW_W-1:0]   off_k;
  logic [DATA_WIDTH-1:0] data_k;

  start_edge_sync u_start_sync (
    .clk   (clk),
    .rstn  (rstn),
    .din   (start),
    .pulse (start_pulse)
  );

  // beat_q doubles as the beat index k: it counts beats already completed.
  assign beat_inc = beat_q + (BURST_W+1)'(1);
  assign len_p1   = (BURST_W+1)'(len_q) + (BURST_W+1)'(1);
  assign off_k    = MEM_SW_W'(32'(off_q) + (incr_q ? 32'(beat_q) : 32'd0));
  assign data_k   = DATA_WIDTH'(32'(data_q) + (incr_q ? 32'(beat_q) : 32'd0));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    incr_d    = incr_q;
    dev_d     = dev_q;
    off_d     = off_q;
    data_d    = data_q;
    len_d     = len_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    mwvalid_d = 1'b0;
    wen_d     = wen_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    terr_d    = terr_q;
    beat_d    = beat_q;
    complete  = 1'b0;
`ifdef SEQ_READBACK_EN
    rb_d      = rb_q;
    verr_d    = verr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          mode_d  = mode_sw;
          incr_d  = incr_sw;
          dev_d   = device_addr_sw;
          off_d   = slave_mem_addr_sw;
          data_d  = m_write_data_sw;
          len_d   = burst_len_sw;
          beat_d  = '0;
          terr_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
`ifdef SEQ_READBACK_EN
          rb_d    = 1'b0;
          verr_d  = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (mready) begin
          maddr_d   = ADDR_WIDTH'(compose_maddr(32'(dev_q), 32'(off_k), SLV_AW));
          mwdata_d  = data_k;
          wen_d     = mode_q;
          mwvalid_d = 1'b1;
          state_d   = S_WAIT_ACCEPT;
        end
      end
      S_WAIT_ACCEPT: begin
        if (!mready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Read beats finish only on mrvalid, so a coincident mready is ignored.
        if (!wen_q) begin
          if (mrvalid) begin
            rdata_d  = mrdata;
            complete = 1'b1;
`ifdef SEQ_READBACK_EN
            if (rb_q) begin
              rb_d = 1'b0;
              if (mrdata != mwdata_q) verr_d = 1'b1;
            end else begin
              beat_d = beat_inc;
            end
`else
            beat_d = beat_inc;
`endif
          end
        end else if (mready) begin
          beat_d = beat_inc;
`ifdef SEQ_READBACK_EN
          state_d = S_READBACK;
`else
          complete = 1'b1;
`endif
        end
      end
`ifdef SEQ_READBACK_EN
      S_READBACK: begin
        // Re-read the address just written; maddr/mwdata still hold that beat.
        if (mready) begin
          wen_d     = 1'b0;
          mwvalid_d = 1'b1;
          rb_d      = 1'b1;
          state_d   = S_WAIT_ACCEPT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      if (beat_d == len_p1) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = S_ISSUE;
      end
    end

    // A beat stuck in one state for TIMEOUT_CYCLES cycles aborts the burst.
    if (state_q != S_IDLE && state_d == state_q && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      terr_d  = 1'b1;
`ifdef SEQ_READBACK_EN
      rb_d    = 1'b0;
`endif
    end

    tmo_d = (state_q == S_IDLE || state_d != state_q) ? '0 : tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      incr_q    <= 1'b0;
      dev_q     <= '0;
      off_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      mwvalid_q <= 1'b0;
      wen_q     <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      beat_q    <= '0;
`ifdef SEQ_READBACK_EN
      rb_q      <= 1'b0;
      verr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      incr_q    <= incr_d;
      dev_q     <= dev_d;
      off_q     <= off_d;
      data_q    <= data_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      mwvalid_q <= mwvalid_d;
      wen_q     <= wen_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      beat_q    <= beat_d;
`ifdef SEQ_READBACK_EN
      rb_q      <= rb_d;
      verr_q    <= verr_d;
`endif
    end
  end

  assign maddr       = maddr_q;
  assign mwdata      = mwdata_q;
  assign mwvalid     = mwvalid_q;
  assign wen         = wen_q;
  assign m_read_data = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign beat_count  = beat_q;
`ifdef SEQ_READBACK_EN
  assign verify_err  = verr_q;
`endif

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Directed plus randomized bench for bus_txn_sequencer with a responding
// slave and an address/data reference model built from the burst rules.
module tb_bus_txn_sequencer;

  localparam int AW = 16, DW = 8, SLV_AW = 12, DEV_W = 2, MSW = 6, BW = 4;
  localparam int TMO = 64;

  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, mode_sw = 1'b0, incr_sw = 1'b0;
  logic [DEV_W-1:0] dev_sw = '0;
  logic [MSW-1:0]   off_sw = '0;
  logic [DW-1:0]    data_sw = '0;
  logic [BW-1:0]    len_sw = '0;
  logic [AW-1:0]    maddr;
  logic [DW-1:0]    mwdata, mrdata, m_read_data;
  logic             mwvalid, wen, mrvalid, mready, busy, done, timeout_err;
  logic [BW:0]      beat_count;
`ifdef SEQ_READBACK_EN
  logic             verify_err;
`endif

  always #5 clk = ~clk;

  bus_txn_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode_sw(mode_sw), .incr_sw(incr_sw),
    .device_addr_sw(dev_sw), .slave_mem_addr_sw(off_sw), .m_write_data_sw(data_sw),
    .burst_len_sw(len_sw), .maddr(maddr), .mwdata(mwdata), .mwvalid(mwvalid),
    .wen(wen), .mrdata(mrdata), .mrvalid(mrvalid), .mready(mready),
    .m_read_data(m_read_data), .busy(busy), .done(done), .timeout_err(timeout_err),
`ifdef SEQ_READBACK_EN
    .verify_err(verify_err),
`endif
    .beat_count(beat_count)
  );

  int errors = 0, checks = 0, done_cnt = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic w; } req_t;
  req_t reqs[$];

  logic [DW-1:0] slv_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic          hang = 1'b0, rd_force_en = 1'b0;
  logic [DW-1:0] rd_force_val = '0, rd_xor = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
  endtask

  // Expected bus address for a device and a memory offset.
  function automatic logic [AW-1:0] ref_addr(input int dev, input int off);
    return AW'(dev * (2 ** SLV_AW) + off);
  endfunction

  // Request monitor.
  always @(negedge clk) if (mwvalid === 1'b1) reqs.push_back('{maddr, mwdata, wen});

  // Slave model: accepts after 0-2 cycles, responds after 1-3 more cycles.
  initial begin
    mready = 1'b1; mrvalid = 1'b0; mrdata = '0;
    forever begin
      @(negedge clk);
      if (mwvalid === 1'b1) begin
        if (hang) begin
          mready = 1'b0;
          @(negedge clk);
          mready = 1'b1;
        end else begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          mready = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          if (wen) begin
            slv_mem[maddr] = mwdata;
            mready = 1'b1;
          end else begin
            mrdata  = rd_force_en ? rd_force_val : (slv_mem[maddr] ^ rd_xor);
            mrvalid = 1'b1;
            mready  = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            mrvalid = 1'b0;
            mready  = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_burst(input string tag, input logic m, input logic inc,
                           input int dev, input int off, input int data, input int len);
    req_t got[$];
    int i;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, exp_rd;
    mode_sw = m; incr_sw = inc; dev_sw = DEV_W'(dev); off_sw = MSW'(off);
    data_sw = DW'(data); len_sw = BW'(len);
    reqs.delete(); done_cnt = 0; exp_rd = '0;
    pulse_start();
    i = 0; while (busy !== 1'b1 && i < 20) begin tick(); i++; end
    check($sformatf("%s/busy_rise", tag), 32'(busy), 1);
    i = 0; while (busy === 1'b1 && i < 3000) begin tick(); i++; end
    check($sformatf("%s/busy_fall", tag), 32'(busy), 0);
    repeat (3) tick();
    check($sformatf("%s/done_pulses", tag), done_cnt, 1);
    check($sformatf("%s/beat_count", tag), 32'(beat_count), len + 1);
    check($sformatf("%s/timeout_err", tag), 32'(timeout_err), 0);
    foreach (reqs[j]) begin
`ifdef SEQ_READBACK_EN
      if (m == 1'b0 || reqs[j].w == 1'b1) got.push_back(reqs[j]);
`else
      got.push_back(reqs[j]);
`endif
    end
    check($sformatf("%s/req_count", tag), got.size(), len + 1);
    for (int k = 0; k <= len; k++) begin
      ea = ref_addr(dev, inc ? (off + k) % (2 ** MSW) : off);
      ed = DW'(inc ? (data + k) % (2 ** DW) : data);
      if (k < got.size()) begin
        check($sformatf("%s/maddr[%0d]", tag, k), 32'(got[k].a), 32'(ea));
        check($sformatf("%s/wen[%0d]", tag, k), 32'(got[k].w), 32'(m));
        if (m) check($sformatf("%s/mwdata[%0d]", tag, k), 32'(got[k].d), 32'(ed));
      end
      if (m) ref_mem[ea] = ed;
      else   exp_rd = rd_force_en ? rd_force_val : ref_mem[ea];
    end
    if (!m) check($sformatf("%s/m_read_data", tag), 32'(m_read_data), 32'(exp_rd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, n;
    for (int a = 0; a < 65536; a++) begin slv_mem[a] = '0; ref_mem[a] = '0; end

    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/maddr", 32'(maddr), 0);
    check("rst/mwdata", 32'(mwdata), 0);
    check("rst/ctrl", {27'd0, mwvalid, wen, busy, done, timeout_err}, 0);
    check("rst/m_read_data", 32'(m_read_data), 0);
    check("rst/beat_count", 32'(beat_count), 0);
    rstn = 1'b1;
    repeat (2) tick();

    run_burst("single_wr", 1'b1, 1'b0, 1, 5, 8'hA5, 0);
    check("single_wr/maddr_hold", 32'(maddr), 32'h1005);

    rd_force_en = 1'b1; rd_force_val = 8'h3C;
    run_burst("single_rd", 1'b0, 1'b0, 1, 5, 0, 0);
    rd_force_en = 1'b0;

    run_burst("wrap_wr", 1'b1, 1'b1, 2, 62, 8'hFE, 3);
    run_burst("wrap_rd", 1'b0, 1'b1, 2, 62, 0, 3);
    run_burst("noinc_wr", 1'b1, 1'b0, 3, 17, 8'h6B, 2);

    for (int r = 0; r < 6; r++)
      run_burst($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 255),
                $urandom_range(0, 5));

    // Timeout: the request is accepted, mready returns high, mrvalid never comes.
    hang = 1'b1; mode_sw = 1'b0; incr_sw = 1'b0; len_sw = BW'(2); done_cnt = 0;
    pulse_start();
    i = 0; while (mwvalid !== 1'b1 && i < 30) begin tick(); i++; end
    check("tmo/request_seen", 32'(mwvalid), 1);
    n = 0; while (timeout_err !== 1'b1 && n < 3 * TMO) begin tick(); n++; end
    // One cycle in WAIT_ACCEPT, then TMO cycles in WAIT_DONE before the abort.
    check("tmo/latency", n, TMO + 1);
    check("tmo/timeout_err", 32'(timeout_err), 1);
    check("tmo/busy", 32'(busy), 0);
    repeat (3) tick();
    check("tmo/no_done", done_cnt, 0);
    check("tmo/beat_count", 32'(beat_count), 0);
    hang = 1'b0;
    run_burst("after_tmo", 1'b1, 1'b0, 0, 9, 8'h11, 0);

    // Extra start while busy must not extend or restart the burst.
    mode_sw = 1'b1; incr_sw = 1'b1; dev_sw = 2'd1; off_sw = 6'd40; data_sw = 8'h20;
    len_sw = BW'(3); reqs.delete(); done_cnt = 0;
    pulse_start();
    i = 0; while (busy !== 1'b1 && i < 20) begin tick(); i++; end
    repeat (2) tick();
    pulse_start();
    i = 0; while (busy === 1'b1 && i < 3000) begin tick(); i++; end
    repeat (20) tick();
    check("busy_start/done_pulses", done_cnt, 1);
    check("busy_start/beat_count", 32'(beat_count), 4);
    check("busy_start/req_count", 32'(reqs.size()), 4);
    check("busy_start/busy", 32'(busy), 0);

`ifdef SEQ_READBACK_EN
    rd_xor = 8'h01;
    run_burst("readback_bad", 1'b1, 1'b0, 0, 3, 8'h55, 0);
    check("readback_bad/verify_err", 32'(verify_err), 1);
    rd_xor = 8'h00;
    run_burst("readback_ok", 1'b1, 1'b0, 0, 3, 8'h55, 0);
    check("readback_ok/verify_err", 32'(verify_err), 0);
`endif

    // Asynchronous reset in the middle of a burst.
    mode_sw = 1'b1; incr_sw = 1'b1; dev_sw = 2'd3; off_sw = 6'd1; data_sw = 8'h80;
    len_sw = BW'(7);
    pulse_start();
    i = 0; while (beat_count !== 5'd2 && i < 500) begin tick(); i++; end
    check("midrst/reached_beat2", 32'(beat_count), 2);
    #2 rstn = 1'b0;
    #1;
    check("midrst/maddr", 32'(maddr), 0);
    check("midrst/mwdata", 32'(mwdata), 0);
    check("midrst/ctrl", {27'd0, mwvalid, wen, busy, done, timeout_err}, 0);
    check("midrst/beat_count", 32'(beat_count), 0);
    repeat (10) tick();
    rstn = 1'b1;
    done_cnt = 0;
    repeat (10) tick();
    check("midrst/stays_idle", 32'(busy), 0);
    check("midrst/no_done", done_cnt, 0);
    run_burst("post_rst", 1'b1, 1'b0, 2, 33, 8'h5A, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_txn_sequencer.md
Name: bus_txn_sequencer

Overview:
- Switch/button-driven transaction generator that drives one master_interface on a serial_bus.
- Parametrised successor to the single-shot start-pulse harness in the FPGA top: it adds bursts, address/data auto-increment, read-data capture, completion tracking and a per-beat timeout.
- Sits between board I/O (switches, start button, LEDs) and the master_interface user port (mwdata/maddr/mwvalid/wen/mrdata/mrvalid/mready).

Parameters:
- ADDR_WIDTH, 16: bus address width (maddr).
- DATA_WIDTH, 8: data width.
- SLV_AW, 12: slave memory address width inside maddr.
- DEV_W, 2: device-select field width.
- MEM_SW_W, 6: memory-offset switch width; must be <= SLV_AW.
- BURST_W, 4: burst length field width; a burst is burst_len_sw+1 beats.
- TIMEOUT_CYCLES, 4096: maximum cycles per beat in the wait states.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  raw start button, asynchronous to clk.
- mode_sw  in  1  1 = write, 0 = read.
- incr_sw  in  1  1 = auto-increment address and write data per beat.
- device_addr_sw  in  DEV_W  target device.
- slave_mem_addr_sw  in  MEM_SW_W  base memory offset.
- m_write_data_sw  in  DATA_WIDTH  base write data.
- burst_len_sw  in  BURST_W  beats minus 1.
- maddr  out  ADDR_WIDTH  to master_interface.
- mwdata  out  DATA_WIDTH  to master_interface.
- mwvalid  out  1  one-cycle request pulse.
- wen  out  1  transaction mode.
- mrdata  in  DATA_WIDTH  read data.
- mrvalid  in  1  read data valid.
- mready  in  1  master_interface idle/ready.
- m_read_data  out  DATA_WIDTH  last captured read data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.
- timeout_err  out  1  sticky beat timeout.
- beat_count  out  BURST_W+1  beats completed in the current or last burst.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the synchroniser flops are 0. Reset is asynchronous and may land at any point mid-burst; no partial state survives it.
- Start input:
  - start passes through a 2-flop synchroniser followed by rising-edge detect, giving start_pulse.
  - start_pulse is ignored unless the FSM is in IDLE.
- Launch: on an accepted start_pulse, the block latches all switches, clears beat_count and timeout_err, sets busy, and enters ISSUE.
- Address composition:
  - maddr = zero-extended { dev, offset zero-extended to SLV_AW }.
  - dev occupies bits [SLV_AW+DEV_W-1:SLV_AW]; all upper bits are 0.
- Beat k (k = 0..burst_len):
  - With incr set: offset = (base + k) mod 2^MEM_SW_W, and write data = (base_data + k) mod 2^DATA_WIDTH.
  - With incr clear: base offset and base data are reused for every beat.
- FSM states:
  - IDLE: leaves only on an accepted start_pulse (to ISSUE).
  - ISSUE: waits for mready=1, then drives maddr/mwdata/wen and pulses mwvalid for exactly one cycle; then WAIT_ACCEPT.
  - WAIT_ACCEPT: waits for mready=0 (request taken); then WAIT_DONE.
  - WAIT_DONE:
    - Read beat: completes on mrvalid, capturing mrdata into m_read_data that cycle.
    - Write beat: completes on mready=1.
    - On completion, beat_count increments; the FSM goes to ISSUE for the next beat, or to IDLE after the last beat with done pulsed and busy cleared.
- Simultaneous events: if mrvalid and mready=1 coincide on a read beat, the beat completes exactly once.
- Timeout:
  - A per-beat counter runs in ISSUE, WAIT_ACCEPT and WAIT_DONE, and clears on every state transition.
  - If it reaches TIMEOUT_CYCLES-1: timeout_err is set, the burst aborts, the FSM returns to IDLE, done is NOT pulsed, and busy clears.
- Output stability: maddr/mwdata/wen hold their values between beats. m_read_data holds its value until the next mrvalid captured by this block.

Optional Feature:
- Macro: SEQ_READBACK_EN.
- Defined:
  - Each completed write beat is followed by a read of the same address.
  - The readback does not increment beat_count.
  - Extra output verify_err (1 bit, sticky, cleared on an accepted start_pulse) sets when the readback data differs from the written data.
  - Timeout rules apply to the readback as well.
- Undefined: no readback state, no verify_err port.

Decomposition:
- Package bus_seq_pkg holds:
  - FSM state encoding (IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, READBACK);
  - default widths;
  - the maddr compose function.
- Sub-module start_edge_sync (2-flop synchroniser plus rising-edge pulse). Reusable for other buttons.

Test Plan:
- Single write: dev=1, offset=0x05, data=0xA5, burst_len=0, mode=1 -> one mwvalid with maddr=0x1005, mwdata=0xA5, wen=1; done after mready returns; beat_count=1.
- Single read: mode=0, dev=1, offset=0x05, model returns 0x3C on mrvalid -> m_read_data=0x3C; done pulses once; busy low afterwards.
- Incrementing burst with wrap: offset=62, data=0xFE, burst_len=3, incr=1, write -> maddr offsets 62, 63, 0, 1 and data 0xFE, 0xFF, 0x00, 0x01; beat_count=4.
- Timeout: mready held 1 with no mrvalid after the request -> timeout_err=1 at TIMEOUT_CYCLES, no done, FSM in IDLE; the next start clears timeout_err.
- Start during busy, and async reset asserted mid-burst -> extra start ignored (beat count unchanged); reset forces all outputs to 0 immediately.
- SEQ_READBACK_EN: write 0x55, model returns 0x54 on the readback -> verify_err=1; beat_count=1.
